// File: rtl/seg_scan_pkg.sv
// Shared constants for the 7-seg scan driver: FSM encodings, default parameters
// and a width helper.
package seg_scan_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int unsigned DEF_NUM_DIGITS   = 4;
    localparam int unsigned DEF_DATA_W       = 4;
    localparam int unsigned DEF_DWELL_CYCLES = 5;
    localparam int unsigned DEF_BLANK_CYCLES = 0;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned clog2_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/next_digit_finder.sv
// Combinational search for the next enabled digit above cur_idx_c, wrapping to
// the lowest enabled digit when none is higher.
module next_digit_finder
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int unsigned SEL_W      = clog2_w(DEF_NUM_DIGITS)
) (
    input  logic [SEL_W-1:0]      cur_idx_c,
    input  logic [NUM_DIGITS-1:0] mask_c,
    output logic [SEL_W-1:0]      next_idx_c,
    output logic [SEL_W-1:0]      lowest_idx_c,
    output logic                  wrap_c
);

    always_comb begin
        lowest_idx_c = '0;
        next_idx_c   = '0;
        wrap_c       = 1'b1;
        // Descending scans leave the lowest qualifying index as the final write.
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            if (mask_c[i]) lowest_idx_c = SEL_W'(i);
        end
        next_idx_c = lowest_idx_c;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            if (mask_c[i] && (SEL_W'(i) > cur_idx_c)) begin
                next_idx_c = SEL_W'(i);
                wrap_c     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-seg digit scanner with per-frame input snapshot,
// enable masking, leading-zero blanking and optional ghost-guard gaps.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned DWELL_CYCLES = DEF_DWELL_CYCLES,
    parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES,
    localparam int unsigned SEL_W       = clog2_w(NUM_DIGITS)
) (
    input  logic                         clk,
    input  logic                         sys_rst_n,
    input  logic                         scan_en,
    input  logic [NUM_DIGITS*DATA_W-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]        dp_in,
    input  logic [NUM_DIGITS-1:0]        digit_mask,
    input  logic                         lz_suppress,
    output logic [DATA_W-1:0]            data_out,
    output logic                         dp_out,
    output logic [SEL_W-1:0]             digit_sel,
    output logic [NUM_DIGITS-1:0]        digit_onehot,
    output logic                         blank,
    output logic                         frame_tick
);

    localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = clog2_w(CNT_MAX);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(BLANK_CYCLES - 1);

    logic [1:0]                   state, state_nx;
    logic [SEL_W-1:0]             idx, idx_nx;
    logic [CNT_W-1:0]             cnt, cnt_nx;
    logic                         take_snap, tick_nx;

    logic [NUM_DIGITS*DATA_W-1:0] snap_dig, snap_dig_nx;
    logic [NUM_DIGITS-1:0]        snap_dp, snap_dp_nx;
    logic [NUM_DIGITS-1:0]        snap_mask, snap_mask_nx;
    logic                         snap_lz, snap_lz_nx;

    logic [NUM_DIGITS-1:0]        find_mask;
    logic [SEL_W-1:0]             next_idx, lowest_idx;
    logic                         wrap;

    logic [DATA_W-1:0]            val_nx [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]        sup_nx;
    logic                         show_nx;
    logic [DATA_W-1:0]            data_nx;
    logic                         dp_nx;
    logic [NUM_DIGITS-1:0]        onehot_nx;

    // In IDLE the first slot comes from the live mask; mid-frame, from the snapshot.
    assign find_mask = (state == ST_IDLE) ? digit_mask : snap_mask;

    next_digit_finder #(
        .NUM_DIGITS (NUM_DIGITS),
        .SEL_W      (SEL_W)
    ) u_finder (
        .cur_idx_c    (idx),
        .mask_c       (find_mask),
        .next_idx_c   (next_idx),
        .lowest_idx_c (lowest_idx),
        .wrap_c       (wrap)
    );

    // Scan sequencing: dwell, optional gap, advance or wrap to a new frame.
    always_comb begin : fsm_next
        state_nx  = state;
        idx_nx    = idx;
        cnt_nx    = cnt;
        take_snap = 1'b0;
        tick_nx   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (scan_en && (digit_mask != '0)) begin
                    state_nx  = ST_SHOW;
                    idx_nx    = lowest_idx;
                    cnt_nx    = '0;
                    take_snap = 1'b1;
                    tick_nx   = 1'b1;
                end
            end
            ST_SHOW: begin
                if (cnt == DWELL_LAST) begin
                    cnt_nx = '0;
                    if (BLANK_CYCLES > 0) begin
                        state_nx = ST_GAP;
                    end else begin
                        idx_nx    = next_idx;
                        take_snap = wrap;
                        tick_nx   = wrap;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nx    = '0;
                    state_nx  = ST_SHOW;
                    idx_nx    = next_idx;
                    take_snap = wrap;
                    tick_nx   = wrap;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
                idx_nx   = '0;
                cnt_nx   = '0;
            end
        endcase
        if (!scan_en || (digit_mask == '0)) begin
            state_nx  = ST_IDLE;
            idx_nx    = '0;
            cnt_nx    = '0;
            take_snap = 1'b0;
            tick_nx   = 1'b0;
        end
    end

    always_comb begin : snap_next
        snap_dig_nx  = take_snap ? digits_in   : snap_dig;
        snap_dp_nx   = take_snap ? dp_in       : snap_dp;
        snap_mask_nx = take_snap ? digit_mask  : snap_mask;
        snap_lz_nx   = take_snap ? lz_suppress : snap_lz;
    end

    // Leading-zero map: walk down from the top, tracking whether every enabled
    // digit seen so far is a zero without a decimal point.
    always_comb begin : lz_eval
        logic zero_run;
        logic below;
        zero_run = 1'b1;
        below    = 1'b0;
        sup_nx   = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            val_nx[i] = snap_dig_nx[i*DATA_W +: DATA_W];
            below = 1'b0;
            for (int j = 0; j < i; j++) begin
                below = below | snap_mask_nx[j];
            end
            sup_nx[i] = snap_lz_nx && zero_run && (val_nx[i] == '0) && !snap_dp_nx[i] && below;
            if (snap_mask_nx[i]) begin
                zero_run = zero_run && (val_nx[i] == '0) && !snap_dp_nx[i];
            end
        end
    end

    always_comb begin : out_next
        show_nx   = (state_nx == ST_SHOW) && !sup_nx[idx_nx];
        data_nx   = show_nx ? val_nx[idx_nx] : '0;
        dp_nx     = show_nx && snap_dp_nx[idx_nx];
        onehot_nx = show_nx ? (NUM_DIGITS'(1) << idx_nx) : '0;
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= ST_IDLE;
            idx          <= '0;
            cnt          <= '0;
            snap_dig     <= '0;
            snap_dp      <= '0;
            snap_mask    <= '0;
            snap_lz      <= 1'b0;
            data_out     <= '0;
            dp_out       <= 1'b0;
            digit_sel    <= '0;
            digit_onehot <= '0;
            blank        <= 1'b1;
            frame_tick   <= 1'b0;
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            cnt          <= cnt_nx;
            snap_dig     <= snap_dig_nx;
            snap_dp      <= snap_dp_nx;
            snap_mask    <= snap_mask_nx;
            snap_lz      <= snap_lz_nx;
            data_out     <= data_nx;
            dp_out       <= dp_nx;
            digit_sel    <= idx_nx;
            digit_onehot <= onehot_nx;
            blank        <= !show_nx;
            frame_tick   <= tick_nx;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: directed phases push per-cycle expected
// outputs; a negedge monitor pops and compares.
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic        scan_en;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_mask;
    logic        lz_suppress;

    logic [3:0] a_data, g_data;
    logic       a_dp, g_dp;
    logic [1:0] a_sel, g_sel;
    logic [3:0] a_onehot, g_onehot;
    logic       a_blank, g_blank;
    logic       a_tick, g_tick;

    typedef struct packed {
        logic [3:0] onehot;
        logic [3:0] data;
        logic       dp;
        logic [1:0] sel;
        logic       blank;
        logic       tick;
    } obs_t;

    obs_t  exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    mon_cyc = 0;
    logic  chk_gap = 1'b0;
    string phase   = "init";

    always #5 clk = ~clk;

    seg_scan_mux u_dut (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .scan_en      (scan_en),
        .digits_in    (digits_in),
        .dp_in        (dp_in),
        .digit_mask   (digit_mask),
        .lz_suppress  (lz_suppress),
        .data_out     (a_data),
        .dp_out       (a_dp),
        .digit_sel    (a_sel),
        .digit_onehot (a_onehot),
        .blank        (a_blank),
        .frame_tick   (a_tick)
    );

    seg_scan_mux #(.BLANK_CYCLES(2)) u_dut_gap (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .scan_en      (scan_en),
        .digits_in    (digits_in),
        .dp_in        (dp_in),
        .digit_mask   (digit_mask),
        .lz_suppress  (lz_suppress),
        .data_out     (g_data),
        .dp_out       (g_dp),
        .digit_sel    (g_sel),
        .digit_onehot (g_onehot),
        .blank        (g_blank),
        .frame_tick   (g_tick)
    );

    function automatic obs_t grab(input logic g);
        obs_t o;
        if (g) begin
            o.onehot = g_onehot; o.data = g_data; o.dp = g_dp;
            o.sel = g_sel; o.blank = g_blank; o.tick = g_tick;
        end else begin
            o.onehot = a_onehot; o.data = a_data; o.dp = a_dp;
            o.sel = a_sel; o.blank = a_blank; o.tick = a_tick;
        end
        return o;
    endfunction

    task automatic compare(input string name, input obs_t got, input obs_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got onehot=%b data=%h dp=%b sel=%0d blank=%b tick=%b, expected onehot=%b data=%h dp=%b sel=%0d blank=%b tick=%b",
                     name, got.onehot, got.data, got.dp, got.sel, got.blank, got.tick,
                     exp.onehot, exp.data, exp.dp, exp.sel, exp.blank, exp.tick);
        end
    endtask

    // Monitor: one expected record per cycle while the queue holds entries.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                compare($sformatf("%s[%0d]", phase, mon_cyc), grab(chk_gap), exp_q.pop_front());
                mon_cyc++;
            end
        end
    end

    task automatic push_run(input int sel, input logic [3:0] onehot, input logic [3:0] data,
                            input logic dp, input logic tick_first, input int n);
        obs_t r;
        for (int k = 0; k < n; k++) begin
            r.onehot = onehot;
            r.data   = data;
            r.dp     = dp;
            r.sel    = 2'(sel);
            r.blank  = (onehot == 4'b0000);
            r.tick   = tick_first && (k == 0);
            exp_q.push_back(r);
        end
    endtask

    task automatic start_scan(input string name, input logic [15:0] d, input logic [3:0] dp,
                              input logic [3:0] m, input logic lz);
        @(posedge clk); #1;
        scan_en = 1'b0; digits_in = d; dp_in = dp; digit_mask = m; lz_suppress = lz;
        phase = name; mon_cyc = 0;
        @(posedge clk); #1;
        scan_en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s drain_timeout: got %0d records left, expected 0", phase, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t rst_v;
        rst_v.onehot = 4'b0000; rst_v.data = 4'h0; rst_v.dp = 1'b0;
        rst_v.sel = 2'd0; rst_v.blank = 1'b1; rst_v.tick = 1'b0;

        sys_rst_n = 1'b1; scan_en = 1'b0; digits_in = 16'h0; dp_in = 4'h0;
        digit_mask = 4'h0; lz_suppress = 1'b0;
        #1 sys_rst_n = 1'b0;
        #1;
        compare("reset_state", grab(1'b0), rst_v);
        compare("reset_state_gap", grab(1'b1), rst_v);
        repeat (2) @(posedge clk);
        #1 sys_rst_n = 1'b1;
        @(posedge clk); #1;
        compare("idle_scan_off", grab(1'b0), rst_v);

        // All four digits, 5 cycles each, frame tick every 20.
        start_scan("all_digits", 16'h4321, 4'h0, 4'hF, 1'b0);
        for (int f = 0; f < 2; f++)
            for (int s = 0; s < 4; s++)
                push_run(s, 4'(1) << s, 4'(s + 1), 1'b0, s == 0, 5);
        wait_drain();

        // Masked slots 1 and 3 consume no time.
        start_scan("mask_0101", 16'h4321, 4'h0, 4'b0101, 1'b0);
        for (int f = 0; f < 2; f++) begin
            push_run(0, 4'b0001, 4'h1, 1'b0, 1'b1, 5);
            push_run(2, 4'b0100, 4'h3, 1'b0, 1'b0, 5);
        end
        wait_drain();

        // Two-cycle ghost guard after every digit: frame of 28.
        chk_gap = 1'b1;
        start_scan("gap2", 16'h4321, 4'h0, 4'hF, 1'b0);
        for (int f = 0; f < 2; f++)
            for (int s = 0; s < 4; s++) begin
                push_run(s, 4'(1) << s, 4'(s + 1), 1'b0, s == 0, 5);
                push_run(s, 4'b0000, 4'h0, 1'b0, 1'b0, 2);
            end
        wait_drain();
        chk_gap = 1'b0;

        start_scan("lz_0042", 16'h0042, 4'h0, 4'hF, 1'b1);
        for (int f = 0; f < 2; f++) begin
            push_run(0, 4'b0001, 4'h2, 1'b0, 1'b1, 5);
            push_run(1, 4'b0010, 4'h4, 1'b0, 1'b0, 5);
            push_run(2, 4'b0000, 4'h0, 1'b0, 1'b0, 5);
            push_run(3, 4'b0000, 4'h0, 1'b0, 1'b0, 5);
        end
        wait_drain();

        start_scan("lz_0000", 16'h0000, 4'h0, 4'hF, 1'b1);
        push_run(0, 4'b0001, 4'h0, 1'b0, 1'b1, 5);
        push_run(1, 4'b0000, 4'h0, 1'b0, 1'b0, 5);
        push_run(2, 4'b0000, 4'h0, 1'b0, 1'b0, 5);
        push_run(3, 4'b0000, 4'h0, 1'b0, 1'b0, 5);
        wait_drain();

        start_scan("lz_dp2", 16'h0042, 4'b0100, 4'hF, 1'b1);
        push_run(0, 4'b0001, 4'h2, 1'b0, 1'b1, 5);
        push_run(1, 4'b0010, 4'h4, 1'b0, 1'b0, 5);
        push_run(2, 4'b0100, 4'h0, 1'b1, 1'b0, 5);
        push_run(3, 4'b0000, 4'h0, 1'b0, 1'b0, 5);
        wait_drain();

        // New digits arrive during slot 1; visible only from the next frame.
        start_scan("snapshot", 16'h4321, 4'h0, 4'hF, 1'b0);
        for (int s = 0; s < 4; s++) push_run(s, 4'(1) << s, 4'(s + 1), 1'b0, s == 0, 5);
        for (int s = 0; s < 4; s++) push_run(s, 4'(1) << s, 4'(s + 5), 1'b0, s == 0, 5);
        repeat (7) begin @(posedge clk); #1; end
        digits_in = 16'h8765;
        wait_drain();

        // scan_en dropped in slot 1, then restored.
        start_scan("scan_drop", 16'h4321, 4'h0, 4'hF, 1'b0);
        push_run(0, 4'b0001, 4'h1, 1'b0, 1'b1, 5);
        push_run(1, 4'b0010, 4'h2, 1'b0, 1'b0, 2);
        push_run(0, 4'b0000, 4'h0, 1'b0, 1'b0, 2);
        repeat (6) begin @(posedge clk); #1; end
        scan_en = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        scan_en = 1'b1;
        for (int s = 0; s < 4; s++) push_run(s, 4'(1) << s, 4'(s + 1), 1'b0, s == 0, 5);
        wait_drain();

        // Asynchronous reset at dwell count 3, then restart from IDLE.
        start_scan("mid_reset", 16'h4321, 4'h0, 4'hF, 1'b0);
        push_run(0, 4'b0001, 4'h1, 1'b0, 1'b1, 3);
        repeat (3) begin @(posedge clk); #1; end
        sys_rst_n = 1'b0;
        #1;
        compare("async_reset", grab(1'b0), rst_v);
        compare("async_reset_gap", grab(1'b1), rst_v);
        @(posedge clk); #1;
        sys_rst_n = 1'b1;
        @(posedge clk); #1;
        phase = "after_reset"; mon_cyc = 0;
        for (int s = 0; s < 4; s++) push_run(s, 4'(1) << s, 4'(s + 1), 1'b0, s == 0, 5);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
